// File: rtl/coeff_serializer8_30bits_pkg.sv
// Shared widths, lane constants and FSM encoding for the 8-lane coefficient serializer.
package coeff_serializer8_30bits_pkg;

  localparam int COEFF_W = 30;
  localparam int LANES   = 8;
  localparam int SEL_W   = 3;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

  typedef logic [COEFF_W-1:0]            coeff_t;
  typedef logic [LANES-1:0][COEFF_W-1:0] coeff_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/coeff_serializer8_30bits_mux.sv
// 8:1 lane mux for 30-bit coefficients, purely combinational, select 0 picks in1.
module mux8_30bits
  import coeff_serializer8_30bits_pkg::*;
(
  input  logic [COEFF_W-1:0] in1,
  input  logic [COEFF_W-1:0] in2,
  input  logic [COEFF_W-1:0] in3,
  input  logic [COEFF_W-1:0] in4,
  input  logic [COEFF_W-1:0] in5,
  input  logic [COEFF_W-1:0] in6,
  input  logic [COEFF_W-1:0] in7,
  input  logic [COEFF_W-1:0] in8,
  input  logic [SEL_W-1:0]   sel,
  output logic [COEFF_W-1:0] out
);

  always_comb begin
    out = in8;
    case (sel)
      3'd0:    out = in1;
      3'd1:    out = in2;
      3'd2:    out = in3;
      3'd3:    out = in4;
      3'd4:    out = in5;
      3'd5:    out = in6;
      3'd6:    out = in7;
      default: out = in8;
    endcase
  end

endmodule

// File: rtl/coeff_serializer8_30bits.sv
// Serializes one 8-lane coefficient vector into 8 beats, lane 0 first; lane 0 is valid the cycle after capture.
// out_ready low freezes the current lane; in_ready is combinational from out_ready so vectors chain without bubbles.
module coeff_serializer8_30bits
  import coeff_serializer8_30bits_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*COEFF_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COEFF_W-1:0]       out_data,
  output logic [SEL_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy
);

  ser_state_e       state_q;
  logic [SEL_W-1:0] cnt_q;
  coeff_vec_t       vec_q;

  logic at_last;
  logic accept;

  assign at_last = (cnt_q == LAST_IDX);

  // A new vector may enter only when nothing is held or the last lane leaves this cycle.
  assign in_ready = (state_q == IDLE) | ((state_q == SHIFT) & at_last & out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            vec_q   <= coeff_vec_t'(in_data);
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!at_last) begin
              cnt_q <= cnt_q + SEL_W'(1);
            end else if (in_valid) begin
              vec_q <= coeff_vec_t'(in_data);
              cnt_q <= '0;
            end else begin
              // cnt stays at the last index; it only wraps on a fresh capture.
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  mux8_30bits u_lane_mux (
    .in1 (vec_q[0]),
    .in2 (vec_q[1]),
    .in3 (vec_q[2]),
    .in4 (vec_q[3]),
    .in5 (vec_q[4]),
    .in6 (vec_q[5]),
    .in7 (vec_q[6]),
    .in8 (vec_q[7]),
    .sel (cnt_q),
    .out (out_data)
  );

  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;
  assign out_idx   = cnt_q;
  assign out_last  = out_valid & at_last;

endmodule

// File: tb/tb_coeff_serializer8_30bits.sv
// Randomized and directed stimulus for the coefficient serializer, scored against a lane-queue reference model.
module tb_coeff_serializer8_30bits;
  import coeff_serializer8_30bits_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*COEFF_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COEFF_W-1:0]       out_data;
  logic [SEL_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  coeff_serializer8_30bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COEFF_W-1:0] d;
    int                 idx;
  } beat_t;

  // Lanes still owed to the consumer, oldest first.
  beat_t q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [LANES*COEFF_W-1:0] make_vec(input int mode);
    logic [LANES*COEFF_W-1:0] v;
    logic [COEFF_W-1:0]       lane;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        1:       lane = COEFF_W'(k + 1);
        2:       lane = 30'h3FFF_FFFF;
        3:       lane = (k % 2 == 0) ? 30'h2AAA_AAAA : 30'h1555_5555;
        default: lane = COEFF_W'($urandom());
      endcase
      v[k*COEFF_W +: COEFF_W] = lane;
    end
    return v;
  endfunction

  // One clock: drive at posedge+1, check at negedge, then advance the model.
  task automatic cycle(input logic iv, input logic [LANES*COEFF_W-1:0] d, input logic ordy,
                       output logic took);
    logic exp_v;
    logic exp_rdy;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    exp_v   = (q.size() > 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    check_eq("out_valid", 64'(out_valid), 64'(exp_v));
    check_eq("busy", 64'(busy), 64'(exp_v));
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_v) begin
      check_eq("out_data", 64'(out_data), 64'(q[0].d));
      check_eq("out_idx", 64'(out_idx), 64'(q[0].idx));
      check_eq("out_last", 64'(out_last), 64'(q[0].idx == LANES - 1));
    end else begin
      check_eq("out_last_idle", 64'(out_last), 64'(0));
    end
    took = iv && exp_rdy;
    if (exp_v && ordy) void'(q.pop_front());
    if (took) begin
      for (int k = 0; k < LANES; k++) q.push_back('{d: d[k*COEFF_W +: COEFF_W], idx: k});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LANES*COEFF_W-1:0] v);
    logic took;
    took = 1'b0;
    for (int n = 0; n < 20 && !took; n++) cycle(1'b1, v, 1'b1, took);
    check_eq("send_accepted", 64'(took), 64'(1));
  endtask

  task automatic drain();
    logic took;
    for (int n = 0; n < 40 && q.size() > 0; n++) cycle(1'b0, '0, 1'b1, took);
    cycle(1'b0, '0, 1'b1, took);
    check_eq("drained_idle", 64'(out_valid), 64'(0));
  endtask

  task automatic step_to_idx(input int target);
    logic took;
    for (int n = 0; n < 20 && q.size() > 0 && q[0].idx != target; n++)
      cycle(1'b0, '0, 1'b1, took);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check_eq({tag, "_out_data"}, 64'(out_data), 64'(0));
    check_eq({tag, "_out_idx"}, 64'(out_idx), 64'(0));
    check_eq({tag, "_out_last"}, 64'(out_last), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic                     took;
    logic                     iv;
    logic [LANES*COEFF_W-1:0] v;
    logic [LANES*COEFF_W-1:0] v2;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counting lanes 1..8, single vector.
    send(make_vec(1));
    drain();

    // Back-to-back vectors with in_valid held.
    v  = make_vec(0);
    v2 = make_vec(0);
    send(v);
    send(v2);
    drain();

    // Stalling consumer: out_ready 1,0,0 repeating.
    cycle(1'b1, make_vec(0), 1'b1, took);
    for (int n = 0; n < 30; n++) cycle(1'b0, '0, (n % 3 == 0), took);
    drain();

    // Rejected offer mid-vector.
    send(make_vec(0));
    step_to_idx(3);
    cycle(1'b1, make_vec(0), 1'b1, took);
    drain();

    // Asynchronous reset mid-vector.
    send(make_vec(0));
    step_to_idx(5);
    check_eq("pre_reset_idx", 64'(out_idx), 64'(5));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(make_vec(0));
    drain();

    // Bit-exact extremes.
    send(make_vec(2));
    send(make_vec(3));
    drain();

    // Random traffic; offered data is held until accepted.
    v  = make_vec(0);
    iv = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!iv) iv = ($urandom_range(0, 1) == 1);
      cycle(iv, v, ($urandom_range(0, 3) != 0), took);
      if (took) begin
        v  = make_vec(0);
        iv = 1'b0;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
